fetch: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline, the producer side of the IF/ID pipeline register that the decode stage consumes. It holds the PC and drives the instruction-memory address. A direct-mapped BTB with 2-bit counters predicts the next PC. Fetched instruction, PC, PC+4 and prediction flags are registered into IF/ID under the same keep/nop discipline the rest of the pipeline uses.

---
 rtl/fetch.sv | 156 +++++++++++++++
 tb/tb_fetch.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// rtl/fetch.sv - RV32I instruction-fetch stage with a direct-mapped BTB and IF/ID register.
module fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        nop,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype,
  output logic        BTB_hit,
  output logic        is_branch_predict,
  output logic [31:0] pred_target_pype0
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = 30 - IDX;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc;
  logic [31:0] pc_p4;

  logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [TAGW-1:0]        btb_tag_q [BTB_ENTRIES];
  logic [TAGW-1:0]        btb_tag_d [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q [BTB_ENTRIES];
  logic [31:0]            btb_tgt_d [BTB_ENTRIES];
  logic [1:0]             btb_ctr_q [BTB_ENTRIES];
  logic [1:0]             btb_ctr_d [BTB_ENTRIES];

  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pcp4_q, if_pcp4_d;
  logic [31:0] if_insn_q, if_insn_d;
  logic        if_hit_q, if_hit_d;
  logic        if_pred_q, if_pred_d;
  logic [31:0] if_tgt_q, if_tgt_d;

  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic            lk_pred;
  logic [31:0]     lk_tgt;

  logic [IDX-1:0]  up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_hit;

  logic unused_low_bits;

  // Hold the fetch address at RESET_PC for the whole reset window, not just after the first edge.
  assign pc    = rst ? pc_q : RESET_PC;
  assign pc_p4 = pc + 32'd4;
  assign imem_addr = pc;

  assign lk_idx  = pc[IDX+1:2];
  assign lk_tag  = pc[31:IDX+2];
  assign lk_hit  = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
  assign lk_pred = lk_hit && btb_ctr_q[lk_idx][1];
  assign lk_tgt  = btb_tgt_q[lk_idx];

  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[31:IDX+2];
  assign up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

  assign unused_low_bits = ^{redirect_pc[1:0], upd_pc[1:0]};

  always_comb begin
    pc_d = pc_p4;
    if (!rst)          pc_d = RESET_PC;
    else if (redirect) pc_d = {redirect_pc[31:2], 2'b00};
    else if (keep)     pc_d = pc_q;
    else if (lk_pred)  pc_d = lk_tgt;
  end

  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    btb_ctr_d   = btb_ctr_q;
    if (!rst) begin
      btb_valid_d = '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (btb_ctr_q[up_idx] != 2'b11) btb_ctr_d[up_idx] = btb_ctr_q[up_idx] + 2'b01;
          btb_tgt_d[up_idx] = upd_target;
        end else if (btb_ctr_q[up_idx] != 2'b00) begin
          btb_ctr_d[up_idx] = btb_ctr_q[up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        // New entries start weakly taken so the next fetch already follows the branch.
        btb_valid_d[up_idx] = 1'b1;
        btb_tag_d[up_idx]   = up_tag;
        btb_tgt_d[up_idx]   = upd_target;
        btb_ctr_d[up_idx]   = 2'b10;
      end
    end
  end

  always_comb begin
    if_pc_d   = if_pc_q;
    if_pcp4_d = if_pcp4_q;
    if_insn_d = if_insn_q;
    if_hit_d  = if_hit_q;
    if_pred_d = if_pred_q;
    if_tgt_d  = if_tgt_q;
    if (!rst || nop || redirect) begin
      if_pc_d   = '0;
      if_pcp4_d = '0;
      if_insn_d = NOP_INSN;
      if_hit_d  = 1'b0;
      if_pred_d = 1'b0;
      if_tgt_d  = '0;
    end else if (!keep) begin
      if_pc_d   = pc;
      if_pcp4_d = pc_p4;
      if_insn_d = imem_rdata;
      if_hit_d  = lk_hit;
      if_pred_d = lk_pred;
      if_tgt_d  = lk_pred ? lk_tgt : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    pc_q        <= pc_d;
    btb_valid_q <= btb_valid_d;
    btb_tag_q   <= btb_tag_d;
    btb_tgt_q   <= btb_tgt_d;
    btb_ctr_q   <= btb_ctr_d;
    if_pc_q     <= if_pc_d;
    if_pcp4_q   <= if_pcp4_d;
    if_insn_q   <= if_insn_d;
    if_hit_q    <= if_hit_d;
    if_pred_q   <= if_pred_d;
    if_tgt_q    <= if_tgt_d;
  end

  assign PC_pype0          = if_pc_q;
  assign PCp4_pype0        = if_pcp4_q;
  assign Instraction_pype  = if_insn_q;
  assign BTB_hit           = if_hit_q;
  assign is_branch_predict = if_pred_q;
  assign pred_target_pype0 = if_tgt_q;

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - scoreboard bench for the fetch stage.
module tb_fetch;

  localparam logic [31:0] IMASK = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst, keep, nop, redirect, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PC_pype0, PCp4_pype0, Instraction_pype, pred_target_pype0;
  logic        BTB_hit, is_branch_predict;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        bub;
    logic [31:0] pc;
    logic        hit;
    logic        pred;
    logic [31:0] tgt;
    logic [31:0] naddr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ IMASK;

  fetch #(.RESET_PC(32'h0), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .PC_pype0(PC_pype0), .PCp4_pype0(PCp4_pype0), .Instraction_pype(Instraction_pype),
    .BTB_hit(BTB_hit), .is_branch_predict(is_branch_predict),
    .pred_target_pype0(pred_target_pype0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_load(input logic [31:0] pc, input logic hit, input logic pred,
                           input logic [31:0] tgt, input logic [31:0] naddr);
    exp_t e;
    e.bub = 1'b0; e.pc = pc; e.hit = hit; e.pred = pred; e.tgt = tgt; e.naddr = naddr;
    sb.push_back(e);
  endtask

  task automatic push_bubble(input logic [31:0] naddr);
    exp_t e;
    e.bub = 1'b1; e.pc = '0; e.hit = 1'b0; e.pred = 1'b0; e.tgt = '0; e.naddr = naddr;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pc_pype0",    PC_pype0,   e.pc);
      chk("pcp4_pype0",  PCp4_pype0, e.bub ? 32'd0 : e.pc + 32'd4);
      chk("instr_pype",  Instraction_pype, e.bub ? 32'h13 : (e.pc ^ IMASK));
      chk("btb_hit",     {31'd0, BTB_hit}, {31'd0, e.hit});
      chk("predict",     {31'd0, is_branch_predict}, {31'd0, e.pred});
      chk("pred_target", pred_target_pype0, e.tgt);
      chk("imem_addr",   imem_addr, e.naddr);
    end
  endtask

  task automatic idle();
    keep = 0; nop = 0; redirect = 0; redirect_pc = '0;
    upd_valid = 0; upd_pc = '0; upd_target = '0; upd_taken = 0;
  endtask

  task automatic go_to(input logic [31:0] a);
    idle(); redirect = 1; redirect_pc = a;
    push_bubble({a[31:2], 2'b00}); tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 0;
    #1;
    chk("reset_imem_addr", imem_addr, 32'h0);
    push_bubble(32'h0); tick();
    push_bubble(32'h0); tick();
    rst = 1;

    push_load(32'h0, 0, 0, 0, 32'h4); tick();
    push_load(32'h4, 0, 0, 0, 32'h8); tick();

    keep = 1;
    repeat (3) begin push_load(32'h4, 0, 0, 0, 32'h8); tick(); end
    keep = 0;
    push_load(32'h8, 0, 0, 0, 32'hC); tick();
    push_load(32'hC, 0, 0, 0, 32'h10); tick();

    // Same-cycle lookup at the updated index still sees the old (empty) entry.
    upd_valid = 1; upd_pc = 32'h10; upd_target = 32'h40; upd_taken = 1;
    push_load(32'h10, 0, 0, 0, 32'h14); tick();
    go_to(32'h10);
    push_load(32'h10, 1, 1, 32'h40, 32'h40); tick();
    push_load(32'h40, 0, 0, 0, 32'h44); tick();
    go_to(32'h50);
    push_load(32'h50, 0, 0, 0, 32'h54); tick();

    upd_valid = 1; upd_pc = 32'h10; upd_target = 32'h99; upd_taken = 0;
    push_load(32'h54, 0, 0, 0, 32'h58); tick();
    push_load(32'h58, 0, 0, 0, 32'h5C); tick();
    upd_pc = 32'h20;
    push_load(32'h5C, 0, 0, 0, 32'h60); tick();
    go_to(32'h10);
    push_load(32'h10, 1, 0, 0, 32'h14); tick();
    go_to(32'h20);
    push_load(32'h20, 0, 0, 0, 32'h24); tick();

    redirect = 1; redirect_pc = 32'h103; keep = 1;
    push_bubble(32'h100); tick();
    idle();
    push_load(32'h100, 0, 0, 0, 32'h104); tick();

    go_to(32'hFFFF_FFFC);
    push_load(32'hFFFF_FFFC, 0, 0, 0, 32'h0); tick();
    push_load(32'h0, 0, 0, 0, 32'h4); tick();

    // Reset with a pending taken update: the update is dropped and the earlier 0x10 entry is gone.
    rst = 0; upd_valid = 1; upd_pc = 32'h30; upd_target = 32'h80; upd_taken = 1;
    push_bubble(32'h0); tick();
    rst = 1; idle();
    go_to(32'h10);
    push_load(32'h10, 0, 0, 0, 32'h14); tick();
    go_to(32'h30);
    push_load(32'h30, 0, 0, 0, 32'h34); tick();

    nop = 1; keep = 1;
    push_bubble(32'h34); tick();
    idle();
    push_load(32'h34, 0, 0, 0, 32'h38); tick();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
